// File: rtl/image_stream_decimator_if.sv
// AXI4-Stream video link: tuser marks start of frame, tlast marks end of line.
// master drives the payload and tvalid, slave answers with tready.
interface image_stream_decimator_if #(
   parameter int DATA_WIDTH = 24
);
   logic [DATA_WIDTH-1:0] tdata;
   logic                  tvalid;
   logic                  tready;
   logic                  tuser;
   logic                  tlast;

   modport master (output tdata, tvalid, tuser, tlast, input tready);
   modport slave  (input tdata, tvalid, tuser, tlast, output tready);
endinterface

// File: rtl/image_stream_decimator.sv
// Integer-factor raster downscaler: keeps every dec_x-th pixel of every dec_y-th line; 1-cycle registered output.
// Backpressure: single output register, input stalls only while it is full and m_axis_tready is low.
module image_stream_decimator #(
   parameter int DATA_WIDTH = 24,
   parameter int DIM_WIDTH  = 12
) (
   input  logic                  ACLK,
   input  logic                  ARESETN,
   input  logic                  cfg_enable,
   input  logic [DIM_WIDTH-1:0]  cfg_in_width,
   input  logic [DIM_WIDTH-1:0]  cfg_in_height,
   input  logic [3:0]            cfg_dec_x,
   input  logic [3:0]            cfg_dec_y,
   image_stream_decimator_if.slave  s_axis,
   image_stream_decimator_if.master m_axis,
   output logic                  frame_done,
   output logic                  err_eol_early,
   output logic                  err_eol_late,
   output logic                  err_sof_early
);

   typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

   localparam logic [DIM_WIDTH-1:0] DIM_ONE = 1;

   state_t                 state_q, state_d;
   logic [DIM_WIDTH-1:0]   width_q, width_d, height_q, height_d;
   logic [DIM_WIDTH-1:0]   x_q, x_d, y_q, y_d;
   logic [3:0]             dec_x_q, dec_x_d, dec_y_q, dec_y_d;
   logic [3:0]             x_ph_q, x_ph_d, y_ph_q, y_ph_d;
   logic [DATA_WIDTH-1:0]  tdata_q, tdata_d;
   logic                   tvalid_q, tvalid_d, tuser_q, tuser_d, tlast_q, tlast_d;
   logic                   done_q, done_d, eol_early_q, eol_early_d;
   logic                   eol_late_q, eol_late_d, sof_early_q, sof_early_d;

   logic                   s_rdy, accept, keep, at_origin, sof_mid, x_last, line_end;
   logic [DIM_WIDTH-1:0]   width_m1, height_m1;
   logic [DIM_WIDTH:0]     x_plus_dec;

   assign width_m1   = width_q - DIM_ONE;
   assign height_m1  = height_q - DIM_ONE;
   assign at_origin  = (x_q == '0) && (y_q == '0);
   assign keep       = (x_ph_q == 4'd0) && (y_ph_q == 4'd0);
   assign x_last     = (x_q == width_m1);
   assign line_end   = x_last || s_axis.tlast;
   assign sof_mid    = s_axis.tvalid && s_axis.tuser && !at_origin;
   // One extra bit so x + dec_x cannot wrap near the top of the dimension range.
   assign x_plus_dec = {1'b0, x_q} + {{(DIM_WIDTH-3){1'b0}}, dec_x_q};

   always_comb begin
      state_d     = state_q;
      width_d     = width_q;
      height_d    = height_q;
      dec_x_d     = dec_x_q;
      dec_y_d     = dec_y_q;
      x_d         = x_q;
      y_d         = y_q;
      x_ph_d      = x_ph_q;
      y_ph_d      = y_ph_q;
      tdata_d     = tdata_q;
      tvalid_d    = tvalid_q;
      tuser_d     = tuser_q;
      tlast_d     = tlast_q;
      done_d      = 1'b0;
      eol_early_d = 1'b0;
      eol_late_d  = 1'b0;
      sof_early_d = 1'b0;
      s_rdy       = 1'b0;
      accept      = 1'b0;

      // A pending output beat drains whatever state the FSM is in.
      if (tvalid_q && m_axis.tready) begin
         tvalid_d = 1'b0;
      end

      case (state_q)
         IDLE: begin
            s_rdy = !(s_axis.tvalid && s_axis.tuser);
            if (s_axis.tvalid && s_axis.tuser && cfg_enable &&
                (cfg_in_width != '0) && (cfg_in_height != '0)) begin
               width_d  = cfg_in_width;
               height_d = cfg_in_height;
               dec_x_d  = (cfg_dec_x == 4'd0) ? 4'd1 : cfg_dec_x;
               dec_y_d  = (cfg_dec_y == 4'd0) ? 4'd1 : cfg_dec_y;
               x_d      = '0;
               y_d      = '0;
               x_ph_d   = 4'd0;
               y_ph_d   = 4'd0;
               state_d  = RUN;
            end
         end
         RUN: begin
            s_rdy  = (!tvalid_q || m_axis.tready) && !sof_mid;
            accept = s_axis.tvalid && s_rdy;
            if (sof_mid) begin
               sof_early_d = 1'b1;
               state_d     = IDLE;
            end
            if (accept) begin
               if (keep) begin
                  tdata_d  = s_axis.tdata;
                  tvalid_d = 1'b1;
                  tuser_d  = at_origin;
                  tlast_d  = (x_plus_dec >= {1'b0, width_q}) || s_axis.tlast;
               end
               eol_early_d = s_axis.tlast && (x_q < width_m1);
               eol_late_d  = x_last && !s_axis.tlast;
               if (line_end) begin
                  x_d    = '0;
                  x_ph_d = 4'd0;
                  y_d    = y_q + DIM_ONE;
                  y_ph_d = (y_ph_q == dec_y_q - 4'd1) ? 4'd0 : y_ph_q + 4'd1;
                  if (y_q == height_m1) begin
                     done_d  = 1'b1;
                     state_d = IDLE;
                  end
               end else begin
                  x_d    = x_q + DIM_ONE;
                  x_ph_d = (x_ph_q == dec_x_q - 4'd1) ? 4'd0 : x_ph_q + 4'd1;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge ACLK or negedge ARESETN) begin
      if (!ARESETN) begin
         state_q     <= IDLE;
         width_q     <= '0;
         height_q    <= '0;
         dec_x_q     <= 4'd0;
         dec_y_q     <= 4'd0;
         x_q         <= '0;
         y_q         <= '0;
         x_ph_q      <= 4'd0;
         y_ph_q      <= 4'd0;
         tdata_q     <= '0;
         tvalid_q    <= 1'b0;
         tuser_q     <= 1'b0;
         tlast_q     <= 1'b0;
         done_q      <= 1'b0;
         eol_early_q <= 1'b0;
         eol_late_q  <= 1'b0;
         sof_early_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         width_q     <= width_d;
         height_q    <= height_d;
         dec_x_q     <= dec_x_d;
         dec_y_q     <= dec_y_d;
         x_q         <= x_d;
         y_q         <= y_d;
         x_ph_q      <= x_ph_d;
         y_ph_q      <= y_ph_d;
         tdata_q     <= tdata_d;
         tvalid_q    <= tvalid_d;
         tuser_q     <= tuser_d;
         tlast_q     <= tlast_d;
         done_q      <= done_d;
         eol_early_q <= eol_early_d;
         eol_late_q  <= eol_late_d;
         sof_early_q <= sof_early_d;
      end
   end

   assign s_axis.tready = s_rdy;
   assign m_axis.tdata  = tdata_q;
   assign m_axis.tvalid = tvalid_q;
   assign m_axis.tuser  = tuser_q;
   assign m_axis.tlast  = tlast_q;
   assign frame_done    = done_q;
   assign err_eol_early = eol_early_q;
   assign err_eol_late  = eol_late_q;
   assign err_sof_early = sof_early_q;

endmodule

// File: tb/tb_image_stream_decimator.sv
// Randomized bench for image_stream_decimator against a coordinate-arithmetic raster model.
module tb_image_stream_decimator;
   localparam int DW   = 24;
   localparam int DIMW = 12;

   logic            ACLK = 1'b0;
   logic            ARESETN = 1'b0;
   logic            cfg_enable;
   logic [DIMW-1:0] cfg_in_width, cfg_in_height;
   logic [3:0]      cfg_dec_x, cfg_dec_y;
   logic            frame_done, err_eol_early, err_eol_late, err_sof_early;

   image_stream_decimator_if #(.DATA_WIDTH(DW)) s_if ();
   image_stream_decimator_if #(.DATA_WIDTH(DW)) m_if ();

   image_stream_decimator #(.DATA_WIDTH(DW), .DIM_WIDTH(DIMW)) dut (
      .ACLK          (ACLK),
      .ARESETN       (ARESETN),
      .cfg_enable    (cfg_enable),
      .cfg_in_width  (cfg_in_width),
      .cfg_in_height (cfg_in_height),
      .cfg_dec_x     (cfg_dec_x),
      .cfg_dec_y     (cfg_dec_y),
      .s_axis        (s_if),
      .m_axis        (m_if),
      .frame_done    (frame_done),
      .err_eol_early (err_eol_early),
      .err_eol_late  (err_eol_late),
      .err_sof_early (err_sof_early)
   );

   always #5 ACLK = ~ACLK;

   // Input beats are {tuser, tlast, tdata}; output beats {6'b0, tuser, tlast, tdata}.
   logic [25:0] in_q[$];
   logic [31:0] exp_q[$];
   logic [31:0] out_q[$];
   int n_checks = 0;
   int n_fail   = 0;
   int n_done, n_early, n_late, n_sof;
   int first_s, first_m;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
      n_checks++;
      if (got !== want) begin
         n_fail++;
         $display("FAIL %s: got %0h want %0h", tag, got, want);
      end
   endtask

   task automatic set_cfg(input int w, input int h, input int dx, input int dy);
      cfg_enable    = 1'b1;
      cfg_in_width  = DIMW'(w);
      cfg_in_height = DIMW'(h);
      cfg_dec_x     = 4'(dx);
      cfg_dec_y     = 4'(dy);
   endtask

   // Reference: a pixel survives when x % dx == 0 and y % dy == 0; it closes its
   // output line when no further kept pixel fits in the input line.
   function automatic void add_frame(input int w, input int h, input int dx, input int dy,
                                     input bit rnd, input int base);
      int edx, edy;
      logic [23:0] d;
      logic u, l;
      edx = (dx == 0) ? 1 : dx;
      edy = (dy == 0) ? 1 : dy;
      for (int y = 0; y < h; y++) begin
         for (int x = 0; x < w; x++) begin
            d = rnd ? 24'($urandom) : 24'(base + y * w + x);
            u = (x == 0 && y == 0);
            l = (x == w - 1);
            in_q.push_back({u, l, d});
            if ((x % edx == 0) && (y % edy == 0))
               exp_q.push_back({6'd0, u, (x + edx >= w), d});
         end
      end
   endfunction

   // rdy_mode: 0 always ready, 1 toggling, 2 random.
   task automatic run_stream(input int gap_pct, input int rdy_mode, input bit scramble);
      int idx, cyc, quiet;
      bit s_hs, m_hs, stalled;
      logic [31:0] stall_p, cur_p;
      idx = 0; cyc = 0; quiet = 0; stalled = 1'b0; stall_p = '0;
      first_s = -1; first_m = -1;
      out_q.delete();
      n_done = 0; n_early = 0; n_late = 0; n_sof = 0;
      @(posedge ACLK); #1;
      s_if.tvalid = 1'b0;
      m_if.tready = 1'b1;
      while (1) begin
         if (idx < in_q.size()) begin
            {s_if.tuser, s_if.tlast, s_if.tdata} = in_q[idx];
            if (!s_if.tvalid) s_if.tvalid = ($urandom_range(99) >= gap_pct);
         end else begin
            s_if.tvalid = 1'b0;
         end
         @(negedge ACLK);
         s_hs  = s_if.tvalid && s_if.tready;
         m_hs  = m_if.tvalid && m_if.tready;
         cur_p = {6'd0, m_if.tuser, m_if.tlast, m_if.tdata};
         if (stalled) begin
            check("stall_vld", 32'(m_if.tvalid), 32'd1);
            check("stall_dat", cur_p, stall_p);
         end
         stalled = m_if.tvalid && !m_if.tready;
         stall_p = cur_p;
         if (s_hs && first_s < 0) first_s = cyc;
         if (m_hs) begin
            out_q.push_back(cur_p);
            if (first_m < 0) first_m = cyc;
         end
         n_done  += int'(frame_done);
         n_early += int'(err_eol_early);
         n_late  += int'(err_eol_late);
         n_sof   += int'(err_sof_early);
         @(posedge ACLK); #1;
         cyc++;
         if (s_hs) begin
            idx++;
            s_if.tvalid = 1'b0;
         end
         if (scramble && idx > 0) begin
            cfg_in_width  = DIMW'($urandom_range(0, 20));
            cfg_in_height = DIMW'($urandom_range(0, 10));
            cfg_dec_x     = 4'($urandom);
            cfg_dec_y     = 4'($urandom);
         end
         case (rdy_mode)
            0:       m_if.tready = 1'b1;
            1:       m_if.tready = ~m_if.tready;
            default: m_if.tready = 1'($urandom_range(1));
         endcase
         if (idx >= in_q.size() && !m_if.tvalid) quiet++;
         else quiet = 0;
         if (quiet >= 4) break;
         if (cyc >= 5000) begin
            check("timeout_idx", 32'(idx), 32'(in_q.size()));
            check("timeout_vld", 32'(m_if.tvalid), 32'd0);
            break;
         end
      end
      s_if.tvalid = 1'b0;
      m_if.tready = 1'b1;
   endtask

   task automatic check_frame(input string tag, input int done_w, input int early_w,
                              input int late_w, input int sof_w);
      check({tag, "_cnt"}, 32'(out_q.size()), 32'(exp_q.size()));
      for (int i = 0; i < out_q.size() && i < exp_q.size(); i++)
         check({tag, "_beat"}, out_q[i], exp_q[i]);
      check({tag, "_done"},  32'(n_done),  32'(done_w));
      check({tag, "_early"}, 32'(n_early), 32'(early_w));
      check({tag, "_late"},  32'(n_late),  32'(late_w));
      check({tag, "_sof"},   32'(n_sof),   32'(sof_w));
      in_q.delete();
      exp_q.delete();
   endtask

   initial begin
      int w, h, dx, dy;
      set_cfg(4, 2, 1, 1);
      s_if.tvalid = 1'b0; s_if.tuser = 1'b0; s_if.tlast = 1'b0; s_if.tdata = '0;
      m_if.tready = 1'b1;
      repeat (3) @(posedge ACLK);
      #1 ARESETN = 1'b1;
      @(negedge ACLK);
      check("rst_m_vld",  32'(m_if.tvalid), 32'd0);
      check("rst_m_dat",  32'(m_if.tdata),  32'd0);
      check("rst_m_usr",  32'({m_if.tuser, m_if.tlast}), 32'd0);
      check("rst_pulses", 32'({frame_done, err_eol_early, err_eol_late, err_sof_early}), 32'd0);
      check("rst_s_rdy",  32'(s_if.tready), 32'd1);

      set_cfg(4, 2, 1, 1);
      add_frame(4, 2, 1, 1, 1'b0, 0);
      run_stream(0, 0, 1'b0);
      check("pass_latency", 32'(first_m - first_s), 32'd1);
      check_frame("pass", 1, 0, 0, 0);

      set_cfg(8, 4, 2, 2);
      add_frame(8, 4, 2, 2, 1'b0, 0);
      run_stream(0, 0, 1'b0);
      check_frame("dec22", 1, 0, 0, 0);

      set_cfg(5, 3, 2, 2);
      add_frame(5, 3, 2, 2, 1'b0, 0);
      run_stream(0, 0, 1'b0);
      check_frame("odd", 1, 0, 0, 0);

      set_cfg(8, 4, 2, 2);
      add_frame(8, 4, 2, 2, 1'b0, 0);
      run_stream(30, 1, 1'b0);
      check_frame("bp", 1, 0, 0, 0);

      set_cfg(6, 3, 3, 0);
      add_frame(6, 3, 3, 0, 1'b1, 0);
      add_frame(6, 3, 3, 0, 1'b1, 0);
      run_stream(0, 0, 1'b0);
      check_frame("b2b", 2, 0, 0, 0);

      // Line 0 ends early at x = 2; line 1 must restart at x = 0.
      set_cfg(8, 2, 1, 1);
      for (int x = 0; x < 3; x++) begin
         in_q.push_back({(x == 0), (x == 2), 24'(x)});
         exp_q.push_back({6'd0, (x == 0), (x == 2), 24'(x)});
      end
      for (int x = 0; x < 8; x++) begin
         in_q.push_back({1'b0, (x == 7), 24'(16 + x)});
         exp_q.push_back({6'd0, 1'b0, (x == 7), 24'(16 + x)});
      end
      run_stream(0, 0, 1'b0);
      check_frame("eol_early", 1, 1, 0, 0);

      set_cfg(4, 2, 1, 1);
      add_frame(4, 2, 1, 1, 1'b0, 0);
      in_q[3][24] = 1'b0;
      run_stream(10, 2, 1'b0);
      check_frame("eol_late", 1, 0, 1, 0);

      // New SOF arrives at (3, 1): the partial frame is abandoned, the new one runs whole.
      set_cfg(8, 2, 1, 1);
      add_frame(8, 2, 1, 1, 1'b0, 0);
      repeat (5) begin
         void'(in_q.pop_back());
         void'(exp_q.pop_back());
      end
      add_frame(8, 2, 1, 1, 1'b0, 100);
      run_stream(0, 0, 1'b0);
      check_frame("sof_early", 1, 0, 0, 1);

      for (int i = 0; i < 6; i++) begin
         w  = $urandom_range(1, 16);
         h  = $urandom_range(1, 8);
         dx = $urandom_range(0, 5);
         dy = $urandom_range(0, 5);
         set_cfg(w, h, dx, dy);
         add_frame(w, h, dx, dy, 1'b1, 0);
         run_stream($urandom_range(0, 50), 2, 1'b1);
         check_frame("rand", 1, 0, 0, 0);
      end

      // Mid-frame reset with a stalled output beat.
      set_cfg(8, 4, 2, 2);
      m_if.tready = 1'b0;
      s_if.tdata = 24'h5A; s_if.tuser = 1'b1; s_if.tlast = 1'b0; s_if.tvalid = 1'b1;
      repeat (4) @(posedge ACLK);
      @(negedge ACLK);
      check("rst_mid_pre_vld", 32'(m_if.tvalid), 32'd1);
      ARESETN = 1'b0;
      #1;
      check("rst_mid_vld", 32'(m_if.tvalid), 32'd0);
      s_if.tvalid = 1'b0;
      repeat (2) @(posedge ACLK);
      #1 ARESETN = 1'b1;
      m_if.tready = 1'b1;
      add_frame(8, 4, 2, 2, 1'b1, 0);
      run_stream(20, 2, 1'b0);
      check_frame("post_rst", 1, 0, 0, 0);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end
endmodule
